uart_rx_cfg: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8-bit receiver. It adds configurable data width, parity mode and stop-bit count. Each bit is decided by a 3-sample majority vote, and the block validates the start bit, reports parity and framing errors, and detects line break. It sits between the pad-side serial input and the byte-stream consumer, and delivers one word per frame with a single-cycle valid strobe.

---
 rtl/uart_rx_cfg.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 3-sample majority per bit, parity/framing
// checks and line-break detection; one dout_vld strobe per frame.
//
// Ports:
//   clk        system clock
//   rst        async active-high reset
//   uart_rx    serial input, async to clk, idle high
//   dout       received word, LSB = first data bit
//   dout_vld   one-cycle strobe, dout and flags valid while high
//   parity_err parity mismatch (always 0 with no parity)
//   frame_err  a checked stop bit was sampled 0
//   break_det  data, parity and first stop bit were all 0
module uart_rx_cfg #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_vld,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] C_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_S0  = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] C_S1  = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] C_DEC = CW'(CLK_DIV / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e state_q, state_d;

  logic                 sync1_q, rxs_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 zero_q, zero_d;

  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 vld_q, vld_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 bd_q, bd_d;

  logic wrap, dec, maj, last_stop, par_exp;

  assign wrap = (cnt_q == C_MAX);
  assign dec  = (cnt_q == C_DEC);
  // third sample is the live rxs at the decision point
  assign maj  = (smp_q[0] & smp_q[1]) |
                (smp_q[0] & rxs_q) |
                (smp_q[1] & rxs_q);
  assign par_exp   = (PARITY == 2) ? ~par_q : par_q;
  assign last_stop = (state_q == STOP) && dec &&
                     (bit_q == S_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      rxs_q   <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (!rxs_q) state_d = START;
      START:
        if (dec && maj)  state_d = IDLE;
        else if (wrap)   state_d = DATA;
      DATA:
        if (wrap && bit_q == B_LAST)
          state_d = (PARITY != 0) ? PAR : STOP;
      PAR:
        if (wrap) state_d = STOP;
      STOP:
        // leave at the last decision point so a
        // following start edge can arrive early
        if (last_stop)
          state_d = zero_d ? WAIT_IDLE : IDLE;
      WAIT_IDLE:
        if (rxs_q) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    shift_d = shift_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    zero_d  = zero_q;
    if (state_q == IDLE) begin
      cnt_d  = '0;
      bit_d  = '0;
      par_d  = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
      zero_d = 1'b1;
    end else if (state_q != WAIT_IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
      if (cnt_q == C_S0) smp_d[0] = rxs_q;
      if (cnt_q == C_S1) smp_d[1] = rxs_q;
    end
    if (dec) begin
      if (state_q == DATA) begin
        shift_d = {maj, shift_q[DATA_BITS-1:1]};
        par_d   = par_q ^ maj;
        zero_d  = zero_q & ~maj;
      end
      if (state_q == PAR) begin
        perr_d = (maj != par_exp);
        zero_d = zero_q & ~maj;
      end
      if (state_q == STOP) begin
        if (!maj) ferr_d = 1'b1;
        // only the first stop bit counts towards break
        if (bit_q == '0) zero_d = zero_q & ~maj;
      end
    end
    if (wrap) begin
      if (state_q == DATA)
        bit_d = (bit_q == B_LAST) ? '0 : bit_q + BW'(1);
      if (state_q == STOP)
        bit_d = bit_q + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    vld_d  = last_stop;
    dout_d = dout_q;
    pe_d   = pe_q;
    fe_d   = fe_q;
    bd_d   = bd_q;
    if (last_stop) begin
      dout_d = shift_q;
      pe_d   = perr_q;
      fe_d   = ferr_d;
      bd_d   = zero_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      pe_q   <= 1'b0;
      fe_q   <= 1'b0;
      bd_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
      pe_q   <= pe_d;
      fe_q   <= fe_d;
      bd_q   <= bd_d;
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = vld_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign break_det  = bd_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: even-parity receiver plus an
// odd-parity receiver listening to the same line.
module tb_uart_rx_cfg;

  localparam int CD  = 16;
  localparam int LAT = 2 + 1 + (1 + 8 + 1 + 1 - 1) * CD + CD / 2 + 1 + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] dout, dout_o;
  logic       vld, pe, fe, bd;
  logic       vld_o, pe_o, fe_o, bd_o;

  uart_rx_cfg #(
    .CLK_DIV(CD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(rx),
    .dout(dout), .dout_vld(vld),
    .parity_err(pe), .frame_err(fe), .break_det(bd)
  );

  uart_rx_cfg #(
    .CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) dut_odd (
    .clk(clk), .rst(rst), .uart_rx(rx),
    .dout(dout_o), .dout_vld(vld_o),
    .parity_err(pe_o), .frame_err(fe_o), .break_det(bd_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int odd_cnt = 0;
  int fall_cyc = 0;

  logic [7:0] h_dout [32];
  logic [2:0] h_flg  [32];
  int         h_cyc  [32];
  logic [7:0] odd_dout = '0;
  logic [2:0] odd_flg  = '0;

  // strobe monitor, sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (vld) begin
      if (vld_cnt < 32) begin
        h_dout[vld_cnt] = dout;
        h_flg[vld_cnt]  = {pe, fe, bd};
        h_cyc[vld_cnt]  = cyc;
      end
      vld_cnt++;
    end
    if (vld_o) begin
      odd_cnt++;
      odd_dout = dout_o;
      odd_flg  = {pe_o, fe_o, bd_o};
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // frame bits LSB first: start, data, parity, stop
  function automatic logic [10:0] frame(input logic [7:0] d,
                                        input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  // n bits; the last lasts last_len cycles; bit gbit gets a
  // one-cycle inverted pulse 9 cycles into the bit
  task automatic tx(input logic [10:0] f, input int n,
                    input int last_len, input int gbit);
    int len;
    for (int b = 0; b < n; b++) begin
      if (b == 0) fall_cyc = cyc;
      len = (b == n - 1) ? last_len : CD;
      for (int c = 0; c < len; c++) begin
        if (b == gbit && c == 9) rx = ~f[b];
        else                     rx = f[b];
        @(negedge clk);
      end
    end
    rx = 1'b1;
  endtask

  task automatic wait_cnt(input int target, input int budget);
    for (int i = 0; i < budget && vld_cnt < target; i++)
      @(negedge clk);
  endtask

  initial begin
    // reset
    repeat (4) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_flags", 32'({pe, fe, bd}), 32'h0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // 1: 0xA5 even parity 0, latency
    tx(frame(8'hA5, 1'b0), 11, CD, -1);
    wait_cnt(1, 64);
    chk("a5_cnt", 32'(vld_cnt), 32'd1);
    chk("a5_dout", 32'(h_dout[0]), 32'hA5);
    chk("a5_flags", 32'(h_flg[0]), 32'h0);
    chk("a5_lat", 32'(h_cyc[0] - fall_cyc), 32'(LAT));
    repeat (8) @(negedge clk);

    // 2: 0x01 with parity bit 0: bad even, good odd
    tx(frame(8'h01, 1'b0), 11, CD, -1);
    wait_cnt(2, 64);
    chk("p01_cnt", 32'(vld_cnt), 32'd2);
    chk("p01_dout", 32'(h_dout[1]), 32'h01);
    chk("p01_flags", 32'(h_flg[1]), 32'b100);
    chk("odd_cnt", 32'(odd_cnt), 32'd2);
    chk("odd_dout", 32'(odd_dout), 32'h01);
    chk("odd_flags", 32'(odd_flg), 32'h0);
    repeat (8) @(negedge clk);

    // 3: 4-cycle low pulse is a false start
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("false_start", 32'(vld_cnt), 32'd2);
    tx(frame(8'h3C, 1'b0), 11, CD, -1);
    wait_cnt(3, 64);
    chk("3c_cnt", 32'(vld_cnt), 32'd3);
    chk("3c_dout", 32'(h_dout[2]), 32'h3C);
    chk("3c_flags", 32'(h_flg[2]), 32'h0);
    repeat (8) @(negedge clk);

    // 4: break, 20 bit times low
    rx = 1'b0;
    repeat (20 * CD) @(negedge clk);
    chk("brk_cnt", 32'(vld_cnt), 32'd4);
    chk("brk_dout", 32'(h_dout[3]), 32'h00);
    chk("brk_flags", 32'(h_flg[3]), 32'b011);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    chk("brk_hold", 32'(vld_cnt), 32'd4);
    tx(frame(8'h7E, 1'b0), 11, CD, -1);
    wait_cnt(5, 64);
    chk("7e_cnt", 32'(vld_cnt), 32'd5);
    chk("7e_dout", 32'(h_dout[4]), 32'h7E);
    chk("7e_flags", 32'(h_flg[4]), 32'h0);
    repeat (8) @(negedge clk);

    // 5: back-to-back, second start 4 cycles early
    tx(frame(8'h55, 1'b0), 11, CD - 4, -1);
    tx(frame(8'hAA, 1'b0), 11, CD, -1);
    wait_cnt(7, 64);
    chk("b2b_cnt", 32'(vld_cnt), 32'd7);
    chk("b2b_dout0", 32'(h_dout[5]), 32'h55);
    chk("b2b_flags0", 32'(h_flg[5]), 32'h0);
    chk("b2b_dout1", 32'(h_dout[6]), 32'hAA);
    chk("b2b_flags1", 32'(h_flg[6]), 32'h0);
    repeat (8) @(negedge clk);

    // 6: reset mid data bit 4, then glitched frame
    tx(frame(8'hC3, 1'b0), 6, CD / 2, -1);
    rst = 1'b1;
    #1;
    chk("arst_dout", 32'(dout), 32'h0);
    chk("arst_vld", 32'(vld), 32'h0);
    chk("arst_flags", 32'({pe, fe, bd}), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("arst_nostb", 32'(vld_cnt), 32'd7);
    tx(frame(8'hC3, 1'b0), 11, CD, 3);
    wait_cnt(8, 64);
    chk("c3_cnt", 32'(vld_cnt), 32'd8);
    chk("c3_dout", 32'(h_dout[7]), 32'hC3);
    chk("c3_flags", 32'(h_flg[7]), 32'h0);
    chk("c3_lat", 32'(h_cyc[7] - fall_cyc), 32'(LAT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
